// File: rtl/stream_mux_arb.sv
// stream_mux_arb
//   Merges CHANNELS valid/ready input streams of WIDTH bits onto a single
//   registered valid/ready output stream. There is one cycle of latency and
//   full throughput of one word per cycle. MODE picks the arbitration policy:
//     0 = external select, 1 = fixed priority (lowest index), 2 = round-robin.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   select     channel choice (MODE 0 only)
//   in_valid   per-channel valid
//   in_data    flattened channel data, channel i at [i*WIDTH +: WIDTH]
//   in_ready   per-channel ready (held low while rst_n is low)
//   out_valid  output word valid
//   out_data   registered output word
//   out_chan   index of the channel that supplied out_data
//   out_ready  consumer ready
module stream_mux_arb #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int MODE     = 0,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [SEL_W-1:0]          select,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  input  logic                      out_ready
);

  logic [CHANNELS-1:0] w_gnt;
  logic [SEL_W-1:0]    w_gnt_idx;
  logic [WIDTH-1:0]    w_gnt_data;
  logic [SEL_W-1:0]    w_ptr_nxt;
  logic                w_load_en;
  logic                w_xfer;

  logic                r_vld_p1;
  logic [WIDTH-1:0]    r_data_p1;
  logic [SEL_W-1:0]    r_chan_p1;
  logic [SEL_W-1:0]    r_ptr;

  // Stage 0: combinational grant from the current in_valid and select/pointer
  always_comb begin : grant
    logic found;
    w_gnt = '0;
    found = 1'b0;
    if (MODE == 0) begin
      // An out-of-range select matches no channel, so nothing is granted.
      for (int i = 0; i < CHANNELS; i++) begin
        if (select == SEL_W'(i)) w_gnt[i] = in_valid[i];
      end
    end else if (MODE == 1) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (!found && in_valid[i]) begin
          w_gnt[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end else begin
      // Walk k = 0..CHANNELS-1 positions upward from r_ptr, wrapping modulo
      // CHANNELS; the first valid channel on that walk wins.
      for (int k = 0; k < CHANNELS; k++) begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (!found && in_valid[i] && (i == (int'(r_ptr) + k) % CHANNELS)) begin
            w_gnt[i] = 1'b1;
            found    = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    w_gnt_idx  = '0;
    w_gnt_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_gnt[i]) begin
        w_gnt_idx  = SEL_W'(i);
        w_gnt_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_ptr_nxt = (w_gnt_idx == SEL_W'(CHANNELS - 1)) ? '0 : w_gnt_idx + 1'b1;
  assign w_load_en = ~r_vld_p1 | out_ready;
  // A grant bit is only ever set for a valid channel, so any grant is a transfer.
  assign w_xfer    = (|w_gnt) & w_load_en;
  assign in_ready  = rst_n ? (w_gnt & {CHANNELS{w_load_en}}) : '0;

  // Stage 1: output register; loads a new word or drains when the consumer takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1  <= 1'b0;
      r_data_p1 <= '0;
      r_chan_p1 <= '0;
      r_ptr     <= '0;
    end else if (w_load_en) begin
      if (w_xfer) begin
        r_vld_p1  <= 1'b1;
        r_data_p1 <= w_gnt_data;
        r_chan_p1 <= w_gnt_idx;
        if (MODE == 2) r_ptr <= w_ptr_nxt;
      end else begin
        r_vld_p1  <= 1'b0;
      end
    end
  end

  assign out_valid = r_vld_p1;
  assign out_data  = r_data_p1;
  assign out_chan  = r_chan_p1;

endmodule

// File: tb/tb_stream_mux_arb.sv
module tb_stream_mux_arb;

  typedef struct {
    bit         rst;
    int         dut;
    logic [3:0] v;
    logic [1:0] sel;
    logic       ordy;
    logic [3:0] rdy;
    logic       ov;
    logic [7:0] od;
    logic [1:0] oc;
  } vec_t;

  vec_t tbl[$];

  logic        clk;
  logic        rst_n;
  logic        out_ready;
  logic [1:0]  sel;
  logic [3:0]  in_valid4;
  logic [2:0]  in_valid3;
  logic [31:0] in_data4;
  logic [23:0] in_data3;

  logic [3:0] rdy0, rdy1, rdy2;
  logic [2:0] rdy3, rdy4;
  logic       vld0, vld1, vld2, vld3, vld4;
  logic [7:0] dat0, dat1, dat2, dat3, dat4;
  logic [1:0] chn0, chn1, chn2, chn3, chn4;

  int n_vec = 0;
  int n_err = 0;
  int cur   = 0;

  logic [3:0] a_rdy;
  logic       a_vld;
  logic [7:0] a_dat;
  logic [1:0] a_chn;

  stream_mux_arb #(.WIDTH(8), .CHANNELS(4), .MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .select(sel), .in_valid(in_valid4), .in_data(in_data4),
    .in_ready(rdy0), .out_valid(vld0), .out_data(dat0), .out_chan(chn0), .out_ready(out_ready));
  stream_mux_arb #(.WIDTH(8), .CHANNELS(4), .MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .select(sel), .in_valid(in_valid4), .in_data(in_data4),
    .in_ready(rdy1), .out_valid(vld1), .out_data(dat1), .out_chan(chn1), .out_ready(out_ready));
  stream_mux_arb #(.WIDTH(8), .CHANNELS(4), .MODE(2)) u2 (
    .clk(clk), .rst_n(rst_n), .select(sel), .in_valid(in_valid4), .in_data(in_data4),
    .in_ready(rdy2), .out_valid(vld2), .out_data(dat2), .out_chan(chn2), .out_ready(out_ready));
  stream_mux_arb #(.WIDTH(8), .CHANNELS(3), .MODE(0)) u3 (
    .clk(clk), .rst_n(rst_n), .select(sel), .in_valid(in_valid3), .in_data(in_data3),
    .in_ready(rdy3), .out_valid(vld3), .out_data(dat3), .out_chan(chn3), .out_ready(out_ready));
  stream_mux_arb #(.WIDTH(8), .CHANNELS(3), .MODE(2)) u4 (
    .clk(clk), .rst_n(rst_n), .select(sel), .in_valid(in_valid3), .in_data(in_data3),
    .in_ready(rdy4), .out_valid(vld4), .out_data(dat4), .out_chan(chn4), .out_ready(out_ready));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    a_rdy = '0;
    a_vld = 1'b0;
    a_dat = '0;
    a_chn = '0;
    case (cur)
      0: begin a_rdy = rdy0;         a_vld = vld0; a_dat = dat0; a_chn = chn0; end
      1: begin a_rdy = rdy1;         a_vld = vld1; a_dat = dat1; a_chn = chn1; end
      2: begin a_rdy = rdy2;         a_vld = vld2; a_dat = dat2; a_chn = chn2; end
      3: begin a_rdy = {1'b0, rdy3}; a_vld = vld3; a_dat = dat3; a_chn = chn3; end
      default: begin a_rdy = {1'b0, rdy4}; a_vld = vld4; a_dat = dat4; a_chn = chn4; end
    endcase
  end

  task automatic chk(input string name, input int idx, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s [dut %0d / step %0d]: got 0x%0h, expected 0x%0h", name, cur, idx, act, exp);
    end
  endtask

  task automatic add(input bit r, input int d, input logic [3:0] v, input logic [1:0] s,
                     input logic o, input logic [3:0] rdy, input logic ov,
                     input logic [7:0] od, input logic [1:0] oc);
    vec_t t;
    t.rst = r; t.dut = d; t.v = v; t.sel = s; t.ordy = o;
    t.rdy = rdy; t.ov = ov; t.od = od; t.oc = oc;
    tbl.push_back(t);
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b1;
    sel       = 2'd0;
    in_valid4 = 4'hF;
    in_valid3 = 3'h7;
    in_data4  = 32'h4433_2211;
    in_data3  = 24'hC3_B2A1;

    // Mode 0, 4 channels: select stepping, invalid selected channel, stall
    add(1, 0, 4'hF, 0, 1, 4'h1, 1, 8'h11, 0);
    add(0, 0, 4'hF, 1, 1, 4'h2, 1, 8'h22, 1);
    add(0, 0, 4'hF, 2, 1, 4'h4, 1, 8'h33, 2);
    add(0, 0, 4'hF, 3, 1, 4'h8, 1, 8'h44, 3);
    add(0, 0, 4'hB, 2, 1, 4'h0, 0, 8'h44, 3);
    add(0, 0, 4'hF, 1, 0, 4'h2, 1, 8'h22, 1);
    add(0, 0, 4'hF, 0, 0, 4'h0, 1, 8'h22, 1);
    // Mode 1: lowest index wins
    add(1, 1, 4'hF, 0, 1, 4'h1, 1, 8'h11, 0);
    add(0, 1, 4'hF, 0, 1, 4'h1, 1, 8'h11, 0);
    add(0, 1, 4'hE, 0, 1, 4'h2, 1, 8'h22, 1);
    add(0, 1, 4'hC, 0, 1, 4'h4, 1, 8'h33, 2);
    add(0, 1, 4'h0, 0, 1, 4'h0, 0, 8'h33, 2);
    // Mode 2: rotation, sparse valids, backpressure then no-bubble resume
    add(1, 2, 4'hF, 0, 1, 4'h1, 1, 8'h11, 0);
    add(0, 2, 4'hF, 0, 1, 4'h2, 1, 8'h22, 1);
    add(0, 2, 4'hF, 0, 1, 4'h4, 1, 8'h33, 2);
    add(0, 2, 4'hF, 0, 1, 4'h8, 1, 8'h44, 3);
    add(0, 2, 4'hF, 0, 1, 4'h1, 1, 8'h11, 0);
    add(0, 2, 4'hF, 0, 1, 4'h2, 1, 8'h22, 1);
    add(0, 2, 4'hA, 0, 1, 4'h8, 1, 8'h44, 3);
    add(0, 2, 4'hA, 0, 1, 4'h2, 1, 8'h22, 1);
    add(0, 2, 4'hA, 0, 1, 4'h8, 1, 8'h44, 3);
    add(0, 2, 4'hA, 0, 1, 4'h2, 1, 8'h22, 1);
    add(0, 2, 4'hF, 0, 0, 4'h0, 1, 8'h22, 1);
    add(0, 2, 4'hF, 0, 0, 4'h0, 1, 8'h22, 1);
    add(0, 2, 4'hF, 0, 0, 4'h0, 1, 8'h22, 1);
    add(0, 2, 4'hF, 0, 1, 4'h4, 1, 8'h33, 2);
    add(0, 2, 4'hF, 0, 1, 4'h8, 1, 8'h44, 3);
    // 3 channels, mode 0: out-of-range select grants nothing
    add(1, 3, 4'h7, 3, 1, 4'h0, 0, 8'h00, 0);
    add(0, 3, 4'h7, 2, 1, 4'h4, 1, 8'hC3, 2);
    add(0, 3, 4'h7, 3, 1, 4'h0, 0, 8'hC3, 2);
    // 3 channels, mode 2: wrap from 2 back to 0
    add(1, 4, 4'h7, 0, 1, 4'h1, 1, 8'hA1, 0);
    add(0, 4, 4'h7, 0, 1, 4'h2, 1, 8'hB2, 1);
    add(0, 4, 4'h7, 0, 1, 4'h4, 1, 8'hC3, 2);
    add(0, 4, 4'h7, 0, 1, 4'h1, 1, 8'hA1, 0);
    add(0, 4, 4'h7, 0, 1, 4'h2, 1, 8'hB2, 1);

    // Reset held across clock edges with every channel valid
    @(posedge clk);
    @(posedge clk);
    #1;
    for (int d = 0; d < 5; d++) begin
      cur = d;
      #1;
      chk("reset in_ready",  -1, int'(a_rdy), 0);
      chk("reset out_valid", -1, int'(a_vld), 0);
      chk("reset out_data",  -1, int'(a_dat), 0);
      chk("reset out_chan",  -1, int'(a_chn), 0);
    end

    foreach (tbl[n]) begin
      cur = tbl[n].dut;
      if (tbl[n].rst) begin
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
      end
      in_valid4 = tbl[n].v;
      in_valid3 = tbl[n].v[2:0];
      sel       = tbl[n].sel;
      out_ready = tbl[n].ordy;
      #1;
      chk("in_ready", n, int'(a_rdy), int'(tbl[n].rdy));
      @(posedge clk);
      #1;
      chk("out_valid", n, int'(a_vld), int'(tbl[n].ov));
      chk("out_data",  n, int'(a_dat), int'(tbl[n].od));
      chk("out_chan",  n, int'(a_chn), int'(tbl[n].oc));
    end

    // Async reset pulse mid-stream on the 3-channel round-robin instance
    // (pointer currently at 2, holding word B2 from channel 1)
    cur = 4;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst out_valid", 100, int'(a_vld), 0);
    chk("async rst out_data",  100, int'(a_dat), 0);
    chk("async rst out_chan",  100, int'(a_chn), 0);
    chk("async rst in_ready",  100, int'(a_rdy), 0);
    rst_n = 1'b1;
    #1;
    chk("post rst in_ready", 101, int'(a_rdy), 1);
    @(posedge clk);
    #1;
    chk("post rst out_valid", 102, int'(a_vld), 1);
    chk("post rst out_data",  102, int'(a_dat), 8'hA1);
    chk("post rst out_chan",  102, int'(a_chn), 0);
    @(posedge clk);
    #1;
    chk("post rst out_data",  103, int'(a_dat), 8'hB2);
    chk("post rst out_chan",  103, int'(a_chn), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
